// File: rtl/cpu_mc_control.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_mc_control
//  Purpose  : Multi-cycle control unit for the 16-bit CPU. Steps the shared
//             datapath through fetch / decode / execute / memory / writeback,
//             with a memory-wait timeout, HALT and FAULT terminal states and
//             a count of completed instruction fetches.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    Clock_i        system clock, rising edge
//    Reset_i        synchronous active-high reset
//    Opcode_i[3:0]  IR[15:12], valid from DECODE onward
//    Zero_i         ALU zero flag for the current ALU operation
//    MemReady_i     memory completes the current access this cycle
//    PCWrite_o, IRWrite_o, IorD_o, MemRead_o, MemWrite_o, RegWrite_o,
//    RegDst_o, MemToReg_o, ALUSrcA_o, ALUSrcB_o[1:0], ALUOp_o[1:0],
//    PCSource_o[1:0]            datapath enables and mux selects
//    Halted_o / Fault_o         high in HALT / FAULT
//    IllegalOp_o                one-cycle pulse in DECODE on undefined opcode
//    State_o[3:0]               current state encoding
//    InstrCount_o[CNT_W-1:0]    number of completed fetches (wraps)
// ============================================================================
module cpu_mc_control #(
   parameter int WAIT_MAX = 15,
   parameter int CNT_W    = 16
) (
   input  logic             Clock_i,
   input  logic             Reset_i,
   input  logic [3:0]       Opcode_i,
   input  logic             Zero_i,
   input  logic             MemReady_i,
   output logic             PCWrite_o,
   output logic             IRWrite_o,
   output logic             IorD_o,
   output logic             MemRead_o,
   output logic             MemWrite_o,
   output logic             RegWrite_o,
   output logic             RegDst_o,
   output logic             MemToReg_o,
   output logic             ALUSrcA_o,
   output logic [1:0]       ALUSrcB_o,
   output logic [1:0]       ALUOp_o,
   output logic [1:0]       PCSource_o,
   output logic             Halted_o,
   output logic             Fault_o,
   output logic             IllegalOp_o,
   output logic [3:0]       State_o,
   output logic [CNT_W-1:0] InstrCount_o
);

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_EXEC_R    = 4'd2,
      S_EXEC_I    = 4'd3,
      S_MEM_ADDR  = 4'd4,
      S_MEM_READ  = 4'd5,
      S_MEM_WRITE = 4'd6,
      S_WB_R      = 4'd7,
      S_WB_I      = 4'd8,
      S_WB_MEM    = 4'd9,
      S_BRANCH    = 4'd10,
      S_JUMP      = 4'd11,
      S_HALT      = 4'd12,
      S_FAULT     = 4'd13
   } state_t;

   // Counter only has to reach WAIT_MAX-1.
   localparam int WCNT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
   localparam logic [WCNT_W-1:0] c_WAIT_LIM = WCNT_W'(WAIT_MAX - 1);

   state_t              state_q, state_d;
   logic [WCNT_W-1:0]   wait_q, wait_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic                w_is_mem;
   logic                w_timeout;

   assign w_is_mem  = (state_q == S_FETCH) || (state_q == S_MEM_READ) ||
                      (state_q == S_MEM_WRITE);
   // MemReady on the limit cycle wins, so the timeout needs MemReady low.
   assign w_timeout = (WAIT_MAX != 0) && w_is_mem && !MemReady_i &&
                      (wait_q == c_WAIT_LIM);

   // Next-state logic
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      case (state_q)
         S_FETCH: begin
            if (MemReady_i) begin
               state_d = S_DECODE;
               count_d = count_q + 1'b1;
            end
         end
         S_DECODE: begin
            case (Opcode_i)
               4'b0000:          state_d = S_EXEC_R;
               4'b0001:          state_d = S_EXEC_I;
               4'b0010, 4'b0011: state_d = S_MEM_ADDR;
               4'b0100, 4'b0101: state_d = S_BRANCH;
               4'b0110:          state_d = S_JUMP;
               4'b0111:          state_d = S_HALT;
               default:          state_d = S_FETCH;
            endcase
         end
         S_EXEC_R:    state_d = S_WB_R;
         S_EXEC_I:    state_d = S_WB_I;
         S_MEM_ADDR:  state_d = (Opcode_i == 4'b0011) ? S_MEM_WRITE : S_MEM_READ;
         S_MEM_READ:  if (MemReady_i) state_d = S_WB_MEM;
         S_MEM_WRITE: if (MemReady_i) state_d = S_FETCH;
         S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP: state_d = S_FETCH;
         S_HALT:      state_d = S_HALT;
         S_FAULT:     state_d = S_FAULT;
         default:     state_d = S_FAULT;
      endcase
      if (w_timeout) state_d = S_FAULT;

      // Any state change clears the wait counter, so each memory state
      // starts its own wait budget from zero.
      if (state_d != state_q)
         wait_d = '0;
      else if (w_is_mem && !MemReady_i)
         wait_d = wait_q + 1'b1;
      else
         wait_d = wait_q;
   end

   always_ff @(posedge Clock_i) begin
      if (Reset_i) begin
         state_q <= S_FETCH;
         wait_q  <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         count_q <= count_d;
      end
   end

   // Moore decode from the state register; only FETCH and BRANCH strobes
   // are qualified by MemReady / Zero respectively.
   always_comb begin
      PCWrite_o   = 1'b0;
      IRWrite_o   = 1'b0;
      IorD_o      = 1'b0;
      MemRead_o   = 1'b0;
      MemWrite_o  = 1'b0;
      RegWrite_o  = 1'b0;
      RegDst_o    = 1'b0;
      MemToReg_o  = 1'b0;
      ALUSrcA_o   = 1'b0;
      ALUSrcB_o   = 2'b00;
      ALUOp_o     = 2'b00;
      PCSource_o  = 2'b00;
      Halted_o    = 1'b0;
      Fault_o     = 1'b0;
      IllegalOp_o = 1'b0;
      case (state_q)
         S_FETCH: begin
            MemRead_o = 1'b1;
            ALUSrcB_o = 2'b01;
            IRWrite_o = MemReady_i;
            PCWrite_o = MemReady_i;
         end
         S_DECODE: begin
            ALUSrcB_o   = 2'b10;
            IllegalOp_o = Opcode_i[3];
         end
         S_EXEC_R: begin
            ALUSrcA_o = 1'b1;
            ALUOp_o   = 2'b10;
         end
         S_EXEC_I, S_MEM_ADDR: begin
            ALUSrcA_o = 1'b1;
            ALUSrcB_o = 2'b10;
         end
         S_MEM_READ: begin
            MemRead_o = 1'b1;
            IorD_o    = 1'b1;
         end
         S_MEM_WRITE: begin
            MemWrite_o = 1'b1;
            IorD_o     = 1'b1;
         end
         S_WB_R: begin
            RegWrite_o = 1'b1;
            RegDst_o   = 1'b1;
         end
         S_WB_I: RegWrite_o = 1'b1;
         S_WB_MEM: begin
            RegWrite_o = 1'b1;
            MemToReg_o = 1'b1;
         end
         S_BRANCH: begin
            ALUSrcA_o  = 1'b1;
            ALUOp_o    = 2'b01;
            PCSource_o = 2'b01;
            // Opcode bit 0 distinguishes BNE from BEQ.
            PCWrite_o  = Opcode_i[0] ? ~Zero_i : Zero_i;
         end
         S_JUMP: begin
            PCSource_o = 2'b10;
            PCWrite_o  = 1'b1;
         end
         S_HALT:  Halted_o = 1'b1;
         S_FAULT: Fault_o  = 1'b1;
         default: Fault_o  = 1'b1;
      endcase
      if (Reset_i) begin
         PCWrite_o   = 1'b0;
         IRWrite_o   = 1'b0;
         MemRead_o   = 1'b0;
         MemWrite_o  = 1'b0;
         RegWrite_o  = 1'b0;
         IllegalOp_o = 1'b0;
      end
   end

   assign State_o      = state_q;
   assign InstrCount_o = count_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_mc_control.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cpu_mc_control
//  Purpose  : Self-checking bench for cpu_mc_control. Two instances share the
//             stimulus: one with WAIT_MAX=4/CNT_W=4 (timeout and counter wrap
//             are reachable quickly) and one with default parameters.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cpu_mc_control;

   logic       Clock = 1'b0;
   logic       Reset = 1'b1;
   logic [3:0] Opcode = 4'd0;
   logic       Zero = 1'b0;
   logic       MemReady = 1'b0;

   always #5 Clock = ~Clock;

   typedef struct packed {
      logic       PCWrite, IRWrite, IorD, MemRead, MemWrite;
      logic       RegWrite, RegDst, MemToReg, ALUSrcA;
      logic [1:0] ALUSrcB, ALUOp, PCSource;
      logic       Halted, Fault, IllegalOp;
   } outs_t;

   typedef struct {
      logic [3:0]  st;
      logic [3:0]  st15;
      outs_t       o;
      logic [15:0] cnt;
   } exp_t;

   // Instance A: WAIT_MAX=4, CNT_W=4
   logic a_PCWrite, a_IRWrite, a_IorD, a_MemRead, a_MemWrite, a_RegWrite;
   logic a_RegDst, a_MemToReg, a_ALUSrcA, a_Halted, a_Fault, a_IllegalOp;
   logic [1:0] a_ALUSrcB, a_ALUOp, a_PCSource;
   logic [3:0] a_State, a_Count;
   // Instance B: defaults
   logic b_PCWrite, b_IRWrite, b_IorD, b_MemRead, b_MemWrite, b_RegWrite;
   logic b_RegDst, b_MemToReg, b_ALUSrcA, b_Halted, b_Fault, b_IllegalOp;
   logic [1:0] b_ALUSrcB, b_ALUOp, b_PCSource;
   logic [3:0] b_State;
   logic [15:0] b_Count;

   cpu_mc_control #(.WAIT_MAX(4), .CNT_W(4)) dut_a (
      .Clock_i(Clock), .Reset_i(Reset), .Opcode_i(Opcode), .Zero_i(Zero),
      .MemReady_i(MemReady), .PCWrite_o(a_PCWrite), .IRWrite_o(a_IRWrite),
      .IorD_o(a_IorD), .MemRead_o(a_MemRead), .MemWrite_o(a_MemWrite),
      .RegWrite_o(a_RegWrite), .RegDst_o(a_RegDst), .MemToReg_o(a_MemToReg),
      .ALUSrcA_o(a_ALUSrcA), .ALUSrcB_o(a_ALUSrcB), .ALUOp_o(a_ALUOp),
      .PCSource_o(a_PCSource), .Halted_o(a_Halted), .Fault_o(a_Fault),
      .IllegalOp_o(a_IllegalOp), .State_o(a_State), .InstrCount_o(a_Count)
   );

   cpu_mc_control dut_b (
      .Clock_i(Clock), .Reset_i(Reset), .Opcode_i(Opcode), .Zero_i(Zero),
      .MemReady_i(MemReady), .PCWrite_o(b_PCWrite), .IRWrite_o(b_IRWrite),
      .IorD_o(b_IorD), .MemRead_o(b_MemRead), .MemWrite_o(b_MemWrite),
      .RegWrite_o(b_RegWrite), .RegDst_o(b_RegDst), .MemToReg_o(b_MemToReg),
      .ALUSrcA_o(b_ALUSrcA), .ALUSrcB_o(b_ALUSrcB), .ALUOp_o(b_ALUOp),
      .PCSource_o(b_PCSource), .Halted_o(b_Halted), .Fault_o(b_Fault),
      .IllegalOp_o(b_IllegalOp), .State_o(b_State), .InstrCount_o(b_Count)
   );

   outs_t a_outs;
   assign a_outs = {a_PCWrite, a_IRWrite, a_IorD, a_MemRead, a_MemWrite,
                    a_RegWrite, a_RegDst, a_MemToReg, a_ALUSrcA, a_ALUSrcB,
                    a_ALUOp, a_PCSource, a_Halted, a_Fault, a_IllegalOp};

   exp_t        sb[$];
   exp_t        mon_e;
   int          errors = 0;
   int          checks = 0;
   logic [15:0] m_cnt = 16'd0;

   // Expected output table for each state, straight from the control table.
   function automatic outs_t exp_outs(input logic [3:0] st, input logic rst,
                                      input logic [3:0] op, input logic z,
                                      input logic mr);
      outs_t o;
      o = '0;
      case (st)
         4'd0:  begin o.MemRead = 1; o.ALUSrcB = 2'b01; o.IRWrite = mr; o.PCWrite = mr; end
         4'd1:  begin o.ALUSrcB = 2'b10; o.IllegalOp = (op >= 4'd8); end
         4'd2:  begin o.ALUSrcA = 1; o.ALUSrcB = 2'b00; o.ALUOp = 2'b10; end
         4'd3:  begin o.ALUSrcA = 1; o.ALUSrcB = 2'b10; end
         4'd4:  begin o.ALUSrcA = 1; o.ALUSrcB = 2'b10; end
         4'd5:  begin o.MemRead = 1; o.IorD = 1; end
         4'd6:  begin o.MemWrite = 1; o.IorD = 1; end
         4'd7:  begin o.RegWrite = 1; o.RegDst = 1; end
         4'd8:  begin o.RegWrite = 1; end
         4'd9:  begin o.RegWrite = 1; o.MemToReg = 1; end
         4'd10: begin
            o.ALUSrcA = 1; o.ALUOp = 2'b01; o.PCSource = 2'b01;
            o.PCWrite = (op == 4'b0100) ? z : !z;
         end
         4'd11: begin o.PCSource = 2'b10; o.PCWrite = 1; end
         4'd12: o.Halted = 1;
         4'd13: o.Fault = 1;
         default: o = '0;
      endcase
      if (rst) begin
         o.PCWrite = 0; o.IRWrite = 0; o.MemRead = 0;
         o.MemWrite = 0; o.RegWrite = 0; o.IllegalOp = 0;
      end
      return o;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at time %0t", name, act, expv, $time);
      end
   endtask

   // One clock cycle of stimulus; st/st15 are the hand-derived states of the
   // two instances during this cycle.
   task automatic step2(input logic rst, input logic [3:0] op, input logic z,
                        input logic mr, input logic [3:0] st, input logic [3:0] st15);
      exp_t e;
      Reset = rst; Opcode = op; Zero = z; MemReady = mr;
      e.st   = st;
      e.st15 = st15;
      e.o    = exp_outs(st, rst, op, z, mr);
      e.cnt  = m_cnt;
      sb.push_back(e);
      if (rst) m_cnt = 16'd0;
      else if (st == 4'd0 && mr) m_cnt = m_cnt + 16'd1;
      @(posedge Clock);
      #1;
   endtask

   task automatic step(input logic rst, input logic [3:0] op, input logic z,
                       input logic mr, input logic [3:0] st);
      step2(rst, op, z, mr, st, st);
   endtask

   // Monitor: compare whatever the DUTs present this cycle against the
   // oldest queued expectation.
   always @(negedge Clock) begin
      if (sb.size() != 0) begin
         mon_e = sb.pop_front();
         chk("state_a",  {28'd0, a_State}, {28'd0, mon_e.st});
         chk("state_b",  {28'd0, b_State}, {28'd0, mon_e.st15});
         chk("outs_a",   {14'd0, a_outs},  {14'd0, mon_e.o});
         chk("count_a",  {28'd0, a_Count}, {28'd0, mon_e.cnt[3:0]});
         chk("count_b",  {16'd0, b_Count}, {16'd0, mon_e.cnt});
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
      $fatal(1);
   end

   initial begin
      // Reset for two cycles; state is known only after the first edge.
      @(posedge Clock); #1;
      step(1, 4'h0, 0, 1, 4'd0);

      // R-type: 0,1,2,7 then FETCH with count 1
      step(0, 4'h0, 0, 1, 4'd0); step(0, 4'h0, 0, 1, 4'd1);
      step(0, 4'h0, 0, 1, 4'd2); step(0, 4'h0, 0, 1, 4'd7);
      // ADDI: 0,1,3,8
      step(0, 4'h1, 1, 1, 4'd0); step(0, 4'h1, 1, 1, 4'd1);
      step(0, 4'h1, 1, 1, 4'd3); step(0, 4'h1, 1, 1, 4'd8);
      // LW, 3 wait cycles then ready exactly on the instance-A limit cycle
      step(0, 4'h2, 0, 1, 4'd0); step(0, 4'h2, 0, 1, 4'd1); step(0, 4'h2, 0, 1, 4'd4);
      step(0, 4'h2, 0, 0, 4'd5); step(0, 4'h2, 0, 0, 4'd5); step(0, 4'h2, 0, 0, 4'd5);
      step(0, 4'h2, 0, 1, 4'd5); step(0, 4'h2, 0, 1, 4'd9);
      // BEQ Z=1 (taken), BNE Z=1 (not), BEQ Z=0 (not), BNE Z=0 (taken)
      step(0, 4'h4, 1, 1, 4'd0); step(0, 4'h4, 1, 1, 4'd1); step(0, 4'h4, 1, 1, 4'd10);
      step(0, 4'h5, 1, 1, 4'd0); step(0, 4'h5, 1, 1, 4'd1); step(0, 4'h5, 1, 1, 4'd10);
      step(0, 4'h4, 0, 1, 4'd0); step(0, 4'h4, 0, 1, 4'd1); step(0, 4'h4, 0, 1, 4'd10);
      step(0, 4'h5, 0, 1, 4'd0); step(0, 4'h5, 0, 1, 4'd1); step(0, 4'h5, 0, 1, 4'd10);
      // J
      step(0, 4'h6, 0, 1, 4'd0); step(0, 4'h6, 0, 1, 4'd1); step(0, 4'h6, 0, 1, 4'd11);
      // FETCH waits 2 cycles, then R-type
      step(0, 4'h0, 0, 0, 4'd0); step(0, 4'h0, 0, 0, 4'd0);
      step(0, 4'h0, 0, 1, 4'd0); step(0, 4'h0, 0, 1, 4'd1);
      step(0, 4'h0, 0, 1, 4'd2); step(0, 4'h0, 0, 1, 4'd7);
      // Illegal opcode: one-cycle pulse in DECODE, back to FETCH
      step(0, 4'hA, 0, 1, 4'd0); step(0, 4'hA, 0, 1, 4'd1);

      // SW with memory never ready: A faults after 4 cycles, B keeps waiting
      step(0, 4'h3, 0, 1, 4'd0); step(0, 4'h3, 0, 1, 4'd1); step(0, 4'h3, 0, 0, 4'd4);
      for (int i = 0; i < 4; i++) step2(0, 4'h3, 0, 0, 4'd6, 4'd6);
      for (int i = 0; i < 4; i++) step2(0, 4'h3, 0, 0, 4'd13, 4'd6);
      step2(1, 4'h3, 0, 0, 4'd13, 4'd6);

      // FETCH timeout on A, B keeps fetching-waiting
      for (int i = 0; i < 4; i++) step2(0, 4'h0, 0, 0, 4'd0, 4'd0);
      step2(0, 4'h0, 0, 0, 4'd13, 4'd0);
      step2(1, 4'h0, 0, 0, 4'd13, 4'd0);

      // HALT held 20 cycles with memory ready and Zero toggling
      step(0, 4'h7, 0, 1, 4'd0); step(0, 4'h7, 0, 1, 4'd1);
      for (int i = 0; i < 20; i++) step(0, 4'h7, i[0], 1, 4'd12);
      step(1, 4'h7, 0, 1, 4'd12);

      // 16 fetches via illegal opcodes: A's 4-bit count wraps to 0
      for (int i = 0; i < 16; i++) begin
         step(0, 4'h8 + 4'(i % 8), 0, 1, 4'd0);
         step(0, 4'h8 + 4'(i % 8), 0, 1, 4'd1);
      end

      // LW with reset asserted mid-wait in MEM_READ
      step(0, 4'h2, 0, 1, 4'd0); step(0, 4'h2, 0, 1, 4'd1); step(0, 4'h2, 0, 1, 4'd4);
      step(0, 4'h2, 0, 0, 4'd5); step(0, 4'h2, 0, 0, 4'd5);
      step(1, 4'h2, 0, 0, 4'd5);
      step(0, 4'h0, 0, 1, 4'd0); step(0, 4'h0, 0, 1, 4'd1);
      step(0, 4'h0, 0, 1, 4'd2); step(0, 4'h0, 0, 1, 4'd7);
      step(0, 4'h0, 0, 0, 4'd0);

      repeat (2) @(posedge Clock);
      #1;
      chk("scoreboard_drained", sb.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/cpu_mc_control.md
Name: cpu_mc_control

Overview:
- Multi-cycle control unit for the 16-bit CPU.
- Sequences the shared datapath (PC, IR, register file, ALU, single-port unified memory) through fetch/decode/execute/memory/writeback.
- Takes opcode, ALU Zero and a memory-ready handshake; drives every datapath enable and mux select.
- Adds a memory-wait timeout, HALT/FAULT terminal states and a retired-fetch counter for the bench.

Parameters:
WAIT_MAX, 15, max consecutive MemReady=0 cycles tolerated in one memory state; 0 disables timeout
CNT_W, 16, width of InstrCount

Ports:
Clock  input  1  system clock, rising edge
Reset  input  1  synchronous, active-high reset
Opcode  input  4  IR[15:12], valid from DECODE onward
Zero  input  1  ALU zero flag, combinational from current ALU op
MemReady  input  1  memory completes the current read/write this cycle
PCWrite  output  1  load PC
IRWrite  output  1  load IR from memory data
IorD  output  1  memory address select: 0=PC, 1=ALUOut
MemRead  output  1  memory read strobe
MemWrite  output  1  memory write strobe
RegWrite  output  1  register-file write
RegDst  output  1  destination register: 0=rt, 1=rd
MemToReg  output  1  write data: 0=ALUOut, 1=MDR
ALUSrcA  output  1  ALU A: 0=PC, 1=regA
ALUSrcB  output  2  ALU B: 00=regB, 01=const 1, 10=sign-extended imm, 11=unused
ALUOp  output  2  00=add, 01=sub, 10=decode funct
PCSource  output  2  00=ALU result, 01=ALUOut, 10=jump target
Halted  output  1  high in HALT
Fault  output  1  high in FAULT
IllegalOp  output  1  one-cycle pulse in DECODE for an undefined opcode
State  output  4  current state encoding (debug)
InstrCount  output  CNT_W  count of completed fetches

Behaviour:
- Reset:
  - Synchronous, active-high.
  - At the edge with Reset=1: State←FETCH(0), wait counter←0, InstrCount←0.
  - While Reset=1, PCWrite/IRWrite/MemRead/MemWrite/RegWrite/IllegalOp are forced 0 combinationally.
  - Reset wins over every other event, including HALT, FAULT and mid-memory waits.
- State encoding: FETCH 0, DECODE 1, EXEC_R 2, EXEC_I 3, MEM_ADDR 4, MEM_READ 5, MEM_WRITE 6, WB_R 7, WB_I 8, WB_MEM 9, BRANCH 10, JUMP 11, HALT 12, FAULT 13.
- Unlisted outputs are 0 in each state.
- FETCH:
  - Outputs: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite=PCWrite=MemReady.
  - MemReady=1 → DECODE and InstrCount+1 (wraps 2^CNT_W−1→0). Otherwise stay.
- DECODE:
  - Outputs: ALUSrcA=0, ALUSrcB=10, ALUOp=00 (branch target precomputed into ALUOut).
  - Next state by opcode: 0000 →EXEC_R; 0001 →EXEC_I; 0010/0011 →MEM_ADDR; 0100/0101 →BRANCH; 0110 →JUMP; 0111 →HALT.
  - Opcodes 1000–1111 → FETCH with IllegalOp=1 for this cycle only.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=10 → WB_R.
- WB_R: RegWrite=1, RegDst=1, MemToReg=0 → FETCH.
- EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUOp=00 → WB_I.
- WB_I: RegWrite=1, RegDst=0, MemToReg=0 → FETCH.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00 → MEM_READ if opcode 0010, MEM_WRITE if 0011. Opcode is held stable by IR.
- MEM_READ: MemRead=1, IorD=1. MemReady=1 → WB_MEM, else stay.
- MEM_WRITE: MemWrite=1, IorD=1. MemReady=1 → FETCH, else stay.
- WB_MEM: RegWrite=1, RegDst=0, MemToReg=1 → FETCH.
- BRANCH:
  - Outputs: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=01.
  - PCWrite=Zero for opcode 0100 (BEQ), ~Zero for 0101 (BNE).
  - → FETCH.
- JUMP: PCSource=10, PCWrite=1 → FETCH.
- HALT: Halted=1, all enables 0; held until Reset.
- FAULT: Fault=1, all enables 0; held until Reset.
- Wait timeout (FETCH, MEM_READ, MEM_WRITE only):
  - Counter clears on entry to each memory state.
  - It increments each cycle with MemReady=0.
  - If MemReady=0 when the counter equals WAIT_MAX−1, next state is FAULT and no strobe completes.
  - MemReady=1 on the same cycle the limit would be reached takes priority, and the access completes normally.
  - WAIT_MAX=0: never faults.
- Latencies with MemReady=1 immediately, in cycles from FETCH entry to next FETCH:
  - R-type 4, ADDI 4, LW 5, SW 4, BEQ/BNE 3, J 3.
- Outputs are Moore-decoded from State, except IRWrite/PCWrite in FETCH, which are gated by MemReady, and PCWrite in BRANCH, which is gated by Zero.

Test Plan:
- Reset held 2 cycles, then release with MemReady=1, Opcode=0000 → State sequence 0,1,2,7,0. RegWrite=1 and RegDst=1 only in state 7. InstrCount=1 at second FETCH.
- LW (0010) with MemReady low 3 cycles in MEM_READ, WAIT_MAX=15 → State 0,1,4,5,5,5,5,9,0. MemRead=1 and IorD=1 throughout state 5. MemToReg=1 in state 9.
- BEQ (0100) with Zero=1, then BNE (0101) with Zero=1 → PCWrite=1, PCSource=01 in the first BRANCH; PCWrite=0 in the second.
- SW (0011) with MemReady held 0, WAIT_MAX=4 → 4 cycles in state 6, then State=13, Fault=1, MemWrite=0. Stays 13 until Reset, then State=0 and InstrCount=0.
- Opcode 1010 → IllegalOp=1 for exactly one cycle in DECODE, next State=0. Then Opcode 0111 → State=12, Halted=1, all enables 0 for 20 cycles.
- Preload InstrCount to 0xFFFF via 65535 fetches (or force), one more fetch → InstrCount=0x0000. Reset asserted mid-MEM_READ wait → next State=0, MemRead=0 during Reset.
